// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes, address/data types
// and the hardwired zero-register address.
package rf_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0]   reg_addr_t;
   typedef logic [XLEN_DEF-1:0] xlen_t;

   localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits plus a registered population count, updated together so
// busy_cnt never lags the busy vector.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int AW       = $clog2(NREGS),
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic [AW-1:0]    set_addr,
   input  logic [NREGS-1:0] clr,
   output logic [NREGS-1:0] busy,
   output logic [AW:0]      busy_cnt
);
   logic [NREGS-1:0] busy_reg, busy_next, set_vec;
   logic [AW:0]      cnt_reg, cnt_next;

   always_comb begin
      set_vec = '0;
      if (set && !((ZERO_REG != 0) && (set_addr == AW'(ZERO_ADDR))))
         set_vec[set_addr] = 1'b1;
      // set is applied after clear: a new producer issued in the same cycle keeps the register busy
      busy_next = (busy_reg & ~clr) | set_vec;
      cnt_next  = '0;
      for (int i = 0; i < NREGS; i++)
         cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_reg <= '0;
         cnt_reg  <= '0;
      end else begin
         busy_reg <= busy_next;
         cnt_reg  <= cnt_next;
      end
   end

   assign busy     = busy_reg;
   assign busy_cnt = cnt_reg;
endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file with optional zero register,
// write-to-read bypass and a busy scoreboard for pending writebacks.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int AW       = $clog2(NREGS),
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                sb_set,
   input  logic [AW-1:0]       sb_addr,
   output logic [AW:0]         busy_cnt
);
   logic [XLEN-1:0]  regs [NREGS];
   logic [NWR-1:0]   wr_ok;
   logic [NREGS-1:0] clr_vec;
   logic [NREGS-1:0] busy;

   // Writes to the zero register are filtered here, so neither storage, bypass nor scoreboard sees them
   always_comb begin
      clr_vec = '0;
      for (int j = 0; j < NWR; j++) begin
         wr_ok[j] = wr_en[j] &&
                    !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == AW'(ZERO_ADDR)));
         if (wr_ok[j])
            clr_vec[wr_addr[j*AW +: AW]] = 1'b1;
      end
   end

   // Later ports are assigned last, so the highest-index port wins a collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++)
            regs[r] <= '0;
      end else begin
         for (int j = 0; j < NWR; j++)
            if (wr_ok[j])
               regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
   end

   generate
      for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   ra;
         logic [XLEN-1:0] val;
         logic            bsy;

         assign ra = rd_addr[gi*AW +: AW];

         always_comb begin
            val = regs[ra];
            bsy = busy[ra];
            if (BYPASS != 0) begin
               for (int j = 0; j < NWR; j++)
                  if (wr_ok[j] && (wr_addr[j*AW +: AW] == ra)) begin
                     val = wr_data[j*XLEN +: XLEN];
                     bsy = 1'b0;
                  end
            end
            if ((ZERO_REG != 0) && (ra == AW'(ZERO_ADDR)))
               val = '0;
            // Bypassed write data must not leak out while reset is held
            if (rst) begin
               val = '0;
               bsy = 1'b0;
            end
         end

         assign rd_data[gi*XLEN +: XLEN] = val;
         assign rd_busy[gi]              = bsy;
      end
   endgenerate

   rf_scoreboard #(
      .NREGS   (NREGS),
      .AW      (AW),
      .ZERO_REG(ZERO_REG)
   ) u_sb (
      .clk     (clk),
      .rst     (rst),
      .set     (sb_set),
      .set_addr(sb_addr),
      .clr     (clr_vec),
      .busy    (busy),
      .busy_cnt(busy_cnt)
   );
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a 2-read/2-write bypassing instance and a
// 1-read/1-write non-bypassing instance share clock and reset.
module tb_reg_file_mp;
   import rf_pkg::*;

   logic        clk = 1'b0;
   logic        rst;

   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        sb_set;
   logic [4:0]  sb_addr;
   logic [5:0]  busy_cnt;

   logic [4:0]  nb_rd_addr;
   logic [31:0] nb_rd_data;
   logic [0:0]  nb_rd_busy;
   logic [0:0]  nb_wr_en;
   logic [4:0]  nb_wr_addr;
   logic [31:0] nb_wr_data;
   logic        nb_sb_set;
   logic [4:0]  nb_sb_addr;
   logic [5:0]  nb_busy_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_file_mp #(.NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .sb_set(sb_set), .sb_addr(sb_addr), .busy_cnt(busy_cnt)
   );

   reg_file_mp #(.NRD(1), .NWR(1), .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .clk(clk), .rst(rst),
      .rd_addr(nb_rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
      .wr_en(nb_wr_en), .wr_addr(nb_wr_addr), .wr_data(nb_wr_data),
      .sb_set(nb_sb_set), .sb_addr(nb_sb_addr), .busy_cnt(nb_busy_cnt)
   );

   task automatic check(input string tag, input xlen_t got, input xlen_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end else begin
         $display("ok   %s = %08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int port, input logic [4:0] addr, input xlen_t data);
      wr_en[port]             = 1'b1;
      wr_addr[port*5 +: 5]    = addr;
      wr_data[port*32 +: 32]  = data;
   endtask

   initial begin
      rst = 1'b1;
      rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; sb_set = 1'b0; sb_addr = '0;
      nb_rd_addr = '0; nb_wr_en = '0; nb_wr_addr = '0; nb_wr_data = '0;
      nb_sb_set = 1'b0; nb_sb_addr = '0;
      tick(); tick();
      rst = 1'b0;
      rd_addr = {5'd6, 5'd5};
      #1;
      check("reset_rd_r5", rd_data[31:0], 32'h0);
      check("reset_busy_cnt", {26'd0, busy_cnt}, 32'd0);

      // write r5 then r6 on consecutive cycles; r6 is also seen via bypass
      set_wr(0, 5'd5, 32'h5);
      tick();
      wr_en = '0;
      set_wr(0, 5'd6, 32'h4);
      #1;
      check("wr_r5_next", rd_data[31:0], 32'h5);
      check("bypass_r6", rd_data[63:32], 32'h4);
      tick();
      wr_en = '0;
      #1;
      check("rd_r5", rd_data[31:0], 32'h5);
      check("rd_r6", rd_data[63:32], 32'h4);

      // same-cycle write/read of r7 on both instances
      rd_addr[4:0] = 5'd7;
      set_wr(0, 5'd7, 32'hDEADBEEF);
      nb_rd_addr = 5'd7; nb_wr_en = 1'b1; nb_wr_addr = 5'd7; nb_wr_data = 32'hDEADBEEF;
      #1;
      check("bypass_r7", rd_data[31:0], 32'hDEADBEEF);
      check("nobypass_r7_old", nb_rd_data, 32'h0);
      tick();
      wr_en = '0; nb_wr_en = 1'b0;
      #1;
      check("r7_after", rd_data[31:0], 32'hDEADBEEF);
      check("nobypass_r7_new", nb_rd_data, 32'hDEADBEEF);

      // zero register ignores writes and scoreboard sets
      rd_addr[4:0] = 5'd0;
      set_wr(0, 5'd0, 32'hFFFFFFFF);
      sb_set = 1'b1; sb_addr = 5'd0;
      #1;
      check("r0_same", rd_data[31:0], 32'h0);
      check("r0_busy_same", {31'd0, rd_busy[0]}, 32'd0);
      tick();
      wr_en = '0; sb_set = 1'b0;
      #1;
      check("r0_next", rd_data[31:0], 32'h0);
      check("r0_busy_next", {31'd0, rd_busy[0]}, 32'd0);
      check("r0_busy_cnt", {26'd0, busy_cnt}, 32'd0);

      // write collision: port 1 wins, both in bypass and in storage
      rd_addr[4:0] = 5'd3;
      set_wr(0, 5'd3, 32'h11);
      set_wr(1, 5'd3, 32'h22);
      #1;
      check("collide_bypass", rd_data[31:0], 32'h22);
      tick();
      wr_en = '0;
      #1;
      check("collide_store", rd_data[31:0], 32'h22);

      // scoreboard
      rd_addr[9:5] = 5'd9;
      sb_set = 1'b1; sb_addr = 5'd9;
      tick();
      sb_set = 1'b0;
      #1;
      check("sb_r9_busy", {31'd0, rd_busy[1]}, 32'd1);
      check("sb_cnt1", {26'd0, busy_cnt}, 32'd1);

      set_wr(0, 5'd9, 32'h99);
      sb_set = 1'b1; sb_addr = 5'd9;
      #1;
      check("sb_r9_bypass_busy", {31'd0, rd_busy[1]}, 32'd0);
      tick();
      wr_en = '0; sb_set = 1'b0;
      #1;
      check("sb_set_wins", {31'd0, rd_busy[1]}, 32'd1);
      check("sb_set_wins_cnt", {26'd0, busy_cnt}, 32'd1);
      check("sb_r9_data", rd_data[63:32], 32'h99);

      set_wr(0, 5'd9, 32'h9A);
      tick();
      wr_en = '0;
      #1;
      check("sb_clr_busy", {31'd0, rd_busy[1]}, 32'd0);
      check("sb_clr_cnt", {26'd0, busy_cnt}, 32'd0);

      sb_set = 1'b1; sb_addr = 5'd9;
      tick();
      sb_addr = 5'd4;
      set_wr(0, 5'd9, 32'h9B);
      tick();
      wr_en = '0; sb_set = 1'b0;
      rd_addr = {5'd9, 5'd4};
      #1;
      check("sb_net_cnt", {26'd0, busy_cnt}, 32'd1);
      check("sb_r4_busy", {31'd0, rd_busy[0]}, 32'd1);
      check("sb_r9_idle", {31'd0, rd_busy[1]}, 32'd0);

      sb_set = 1'b1; sb_addr = 5'd11;
      tick();
      sb_set = 1'b0;
      #1;
      check("sb_cnt2", {26'd0, busy_cnt}, 32'd2);

      // asynchronous reset mid-cycle with a write pending
      rd_addr = {5'd5, 5'd12};
      set_wr(0, 5'd12, 32'hCAFE);
      sb_set = 1'b1; sb_addr = 5'd13;
      #2;
      rst = 1'b1;
      #1;
      check("arst_rd0", rd_data[31:0], 32'h0);
      check("arst_rd1", rd_data[63:32], 32'h0);
      check("arst_busy", {30'd0, rd_busy}, 32'd0);
      check("arst_cnt", {26'd0, busy_cnt}, 32'd0);
      tick();
      rst = 1'b0; wr_en = '0; sb_set = 1'b0;
      #1;
      check("post_rst_r5", rd_data[63:32], 32'h0);
      check("post_rst_r12", rd_data[31:0], 32'h0);
      tick();
      check("post_rst_cnt", {26'd0, busy_cnt}, 32'd0);
      check("post_rst_r12_b", rd_data[31:0], 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file for the pipelined core; next generation of the single-cycle register file.
- Adds configurable width, depth and read/write port counts.
- Hardwired zero register and write-to-read bypass.
- Per-register busy scoreboard so the decode stage can detect pending writebacks.
- Sits between decode (read ports, scoreboard set) and writeback (write ports).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >= 2)
AW, $clog2(NREGS), address width (derived, not overridden)
NRD, 2, number of read ports (1..4)
NWR, 1, number of write ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  busy flag of each read address
wr_en  in  NWR  write enables
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
sb_set  in  1  mark sb_addr busy (instruction issued with destination sb_addr)
sb_addr  in  AW  scoreboard set address
busy_cnt  out  AW+1  number of registers currently busy

Behaviour:
- Clock port is clk. Reset port is rst: asynchronous, active-high.
- Reset (rst high, asynchronous):
  - All registers are 0; all busy bits are 0; busy_cnt = 0.
  - rd_data = 0 and rd_busy = 0 while rst is high, independent of clk.
- Reads are combinational (0-cycle latency) from registered state.
- Writes commit on the rising clk edge when wr_en[j] = 1; the data is visible on reads from the next cycle.
- Bypass, when BYPASS = 1:
  - If wr_en[j] = 1 and wr_addr[j] == rd_addr[i] in the same cycle, rd_data[i] = wr_data[j].
  - The highest-index matching write port wins.
  - When BYPASS = 0, reads return the old value until the edge.
- Write collision (NWR = 2, same address, both enabled): port 1 wins; port 0's data is discarded.
- ZERO_REG = 1:
  - Writes to address 0 are dropped.
  - rd_data for address 0 is 0, bypass included.
  - sb_set to address 0 is ignored; busy[0] stays 0.
- Scoreboard:
  - sb_set = 1 sets busy[sb_addr] at the edge.
  - Any committed write to address a clears busy[a] at the edge.
  - Simultaneous sb_set and write to the same address: set wins, busy stays 1 (a new producer is in flight).
  - rd_busy[i] = busy[rd_addr[i]]. When BYPASS = 1 and a same-cycle write to that address exists, rd_busy[i] = 0.
- busy_cnt is registered and always equals the popcount of the busy bits. It is updated at the same edge as the busy bits, including combined set and clear in one cycle.
- Address >= NREGS cannot occur (NREGS is a power of 2).
- No initial-block preload: contents are defined only by reset and writes.
- Reset asserted mid-operation: any in-flight write at the asserting edge is lost. The state is all zero until the first edge after rst deasserts.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN and NREGS defaults.
  - Typedefs: reg_addr_t [AW-1:0] and xlen_t [XLEN-1:0].
  - Constant ZERO_ADDR.
- One sub-module, rf_scoreboard, holds the busy bits and busy_cnt logic, with inputs set, set_addr, the clear vector and rst. The storage array and bypass muxing stay in reg_file_mp.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writes → rd_data = 0, rd_busy = 0 and busy_cnt = 0 immediately. After release, read r5 → 0x00000000.
- Write/read: write r5 = 0x00000005 and r6 = 0x00000004 on consecutive cycles, read ports on r5 and r6 → 0x5 and 0x4 from the cycle after each write.
- Bypass: in the same cycle write r7 = 0xDEADBEEF and read r7 on port 0 → 0xDEADBEEF combinationally. With BYPASS = 0 → old value 0, then 0xDEADBEEF next cycle.
- Zero register: write r0 = 0xFFFFFFFF with sb_set on r0 → read r0 = 0 in the same and next cycles, rd_busy = 0, busy_cnt unchanged.
- Collision (NWR = 2): port 0 writes r3 = 0x11 and port 1 writes r3 = 0x22 → r3 = 0x22 next cycle. Same-cycle bypass read shows 0x22.
- Scoreboard:
  - sb_set r9 → rd_busy = 1, busy_cnt = 1.
  - Write r9 together with sb_set r9 → busy stays 1, busy_cnt = 1.
  - Write r9 alone → busy 0, busy_cnt = 0.
  - sb_set r4 plus write r9 in one cycle → busy_cnt unchanged at net count.
